// File: rtl/mod_pkg.sv
// ============================================================================
// mod_pkg : shared width default and control-strobe encodings for the
//           repeated-subtraction modulo unit (mod_cu / mod_dp / top level).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package mod_pkg;

  localparam int MOD_WIDTH_DEFAULT = 8;

  // Control word packed as {result_enable, write_enable, select}
  localparam logic [2:0] CTL_IDLE = 3'b000;
  localparam logic [2:0] CTL_LOAD = 3'b010;
  localparam logic [2:0] CTL_SUB  = 3'b011;
  localparam logic [2:0] CTL_RES  = 3'b100;

  typedef enum logic [2:0] {
    CU_IDLE  = 3'd0,
    CU_BEGIN = 3'd1,
    CU_SUB   = 3'd2,
    CU_RES   = 3'd3,
    CU_END   = 3'd4
  } cu_state_e;

endpackage

`default_nettype wire

// File: rtl/mod_cmp_sub.sv
// ============================================================================
// mod_cmp_sub : combined subtractor / less-than comparator; lt is the borrow
//               out of one WIDTH+1-bit subtract.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mod_cmp_sub
  import mod_pkg::*;
#(
  parameter int WIDTH = MOD_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             lt
);

  logic [WIDTH:0] full_diff;

  assign full_diff = {1'b0, a} - {1'b0, b};
  assign diff      = full_diff[WIDTH-1:0];
  assign lt        = full_diff[WIDTH];

endmodule

`default_nettype wire

// File: rtl/mod_dp.sv
// ============================================================================
// mod_dp : datapath of the repeated-subtraction modulo unit; working
//          remainder, latched divisor, quotient counter and result registers.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mod_dp
  import mod_pkg::*;
#(
  parameter int WIDTH = MOD_WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             select,
  input  logic             write_enable,
  input  logic             result_enable,
  output logic             less_than,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] quotient,
  output logic             result_valid,
  output logic             div_zero
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic             result_valid_q, result_valid_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH-1:0] sub_diff;
  logic             sub_lt;
  logic             div_is_zero;
  logic [2:0]       ctl;
  logic             do_load;
  logic             do_sub;

  mod_cmp_sub #(
    .WIDTH (WIDTH)
  ) u_cmp_sub (
    .a    (rem_q),
    .b    (div_q),
    .diff (sub_diff),
    .lt   (sub_lt)
  );

  // Zero divisor forces the exit condition so the loop never subtracts 0.
  assign div_is_zero = (div_q == '0);
  assign less_than   = sub_lt | div_is_zero;

  assign ctl     = {result_enable, write_enable, select};
  assign do_load = (ctl[1:0] == CTL_LOAD[1:0]);
  assign do_sub  = (ctl[1:0] == CTL_SUB[1:0]) && !less_than;

  always_comb begin
    rem_d          = rem_q;
    div_d          = div_q;
    quo_d          = quo_q;
    remainder_d    = remainder_q;
    quotient_d     = quotient_q;
    result_valid_d = result_valid_q;
    div_zero_d     = div_zero_q;

    if (do_load) begin
      rem_d          = dividend;
      div_d          = divisor;
      quo_d          = '0;
      result_valid_d = 1'b0;
      div_zero_d     = 1'b0;
    end else if (do_sub) begin
      rem_d = sub_diff;
      quo_d = quo_q + WIDTH'(1);
    end

    // Capture uses pre-update working values even if a write coincides.
    if (ctl[2] == CTL_RES[2]) begin
      remainder_d    = rem_q;
      quotient_d     = quo_q;
      result_valid_d = 1'b1;
      div_zero_d     = div_is_zero;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      rem_q          <= '0;
      div_q          <= '0;
      quo_q          <= '0;
      remainder_q    <= '0;
      quotient_q     <= '0;
      result_valid_q <= 1'b0;
      div_zero_q     <= 1'b0;
    end else begin
      rem_q          <= rem_d;
      div_q          <= div_d;
      quo_q          <= quo_d;
      remainder_q    <= remainder_d;
      quotient_q     <= quotient_d;
      result_valid_q <= result_valid_d;
      div_zero_q     <= div_zero_d;
    end
  end

  assign remainder    = remainder_q;
  assign quotient     = quotient_q;
  assign result_valid = result_valid_q;
  assign div_zero     = div_zero_q;

endmodule

`default_nettype wire

// File: tb/tb_mod_dp.sv
// ============================================================================
// tb_mod_dp : scoreboard bench for mod_dp, sequenced by a negedge control
//             process that behaves like mod_cu.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mod_dp;
  import mod_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] rem;
    logic [W-1:0] quo;
    logic         dz;
    int           lat;
    int           load_cyc;
    string        tag;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [2:0]   ctl = CTL_IDLE;
  logic         select, write_enable, result_enable;
  logic         less_than;
  logic [W-1:0] remainder, quotient;
  logic         result_valid, div_zero;

  assign {result_enable, write_enable, select} = ctl;

  mod_dp #(.WIDTH(W)) dut (
    .CLK           (clk),
    .reset_n       (reset_n),
    .dividend      (dividend),
    .divisor       (divisor),
    .select        (select),
    .write_enable  (write_enable),
    .result_enable (result_enable),
    .less_than     (less_than),
    .remainder     (remainder),
    .quotient      (quotient),
    .result_valid  (result_valid),
    .div_zero      (div_zero)
  );

  always #5 clk = ~clk;

  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  exp_t sb[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: one scoreboard entry per rising edge of result_valid.
  logic prev_rv = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (result_valid === 1'b1 && prev_rv === 1'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_remainder"}, 32'(remainder), 32'(e.rem));
        check({e.tag, "_quotient"},  32'(quotient),  32'(e.quo));
        check({e.tag, "_div_zero"},  32'(div_zero),  32'(e.dz));
        check({e.tag, "_latency"},   32'(cyc - e.load_cyc), 32'(e.lat));
      end
    end
    prev_rv = result_valid;
  end

  // Control sequencer modelled on mod_cu: BEGIN -> SUB (until less_than seen
  // at a posedge, plus that exit cycle) -> RES -> END. abort_after >= 0 stops
  // in SUB after that many SUB cycles without capturing a result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_rem, input logic [W-1:0] exp_quo,
                        input logic exp_dz, input string tag,
                        input int abort_after, output logic [W-1:0] min_rem);
    logic lt_s;
    int   n;
    int   load_cyc;
    exp_t e;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    ctl      = CTL_LOAD;
    @(negedge clk);
    load_cyc = cyc;
    ctl      = CTL_SUB;
    min_rem  = dut.rem_q;
    n        = 0;
    forever begin
      lt_s = less_than;
      @(negedge clk);
      n++;
      if (dut.rem_q < min_rem) min_rem = dut.rem_q;
      if (lt_s) break;
      if (abort_after >= 0 && n >= abort_after) return;
      if (n > 300) begin
        check({tag, "_loop_timeout"}, 32'(n), 32'd0);
        break;
      end
    end
    e.rem = exp_rem; e.quo = exp_quo; e.dz = exp_dz;
    e.lat = 32'(exp_quo) + 2; e.load_cyc = load_cyc; e.tag = tag;
    sb.push_back(e);
    ctl = CTL_RES;
    @(negedge clk);
    ctl = CTL_IDLE;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    logic [W-1:0] mr;
    reset_n = 1'b0;
    ctl     = CTL_IDLE;
    repeat (2) @(negedge clk);
    check("rst_less_than",    32'(less_than),    32'd1);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_remainder",    32'(remainder),    32'd0);
    check("rst_quotient",     32'(quotient),     32'd0);
    check("rst_div_zero",     32'(div_zero),     32'd0);
    reset_n = 1'b1;

    run_op(8'd23, 8'd5, 8'd3, 8'd4, 1'b0, "a23_b5", -1, mr);
    check("a23_b5_min_rem", 32'(mr), 32'd3);
    run_op(8'd4,   8'd9, 8'd4,   8'd0, 1'b0, "a4_b9",   -1, mr);
    run_op(8'd7,   8'd7, 8'd0,   8'd1, 1'b0, "a7_b7",   -1, mr);
    run_op(8'd200, 8'd0, 8'd200, 8'd0, 1'b1, "a200_b0", -1, mr);
    check("a200_b0_no_sub", 32'(mr), 32'd200);
    run_op(8'd255, 8'd1, 8'd0, 8'd255, 1'b0, "a255_b1", -1, mr);

    @(negedge clk);
    dividend = 8'd17;
    divisor  = 8'd2;
    repeat (3) @(negedge clk);
    check("persist_remainder",    32'(remainder),    32'd0);
    check("persist_quotient",     32'(quotient),     32'd255);
    check("persist_result_valid", 32'(result_valid), 32'd1);

    run_op(8'd100, 8'd3, 8'd1, 8'd33, 1'b0, "a100_b3_abort", 10, mr);
    reset_n = 1'b0;
    ctl     = CTL_IDLE;
    @(negedge clk);
    check("midrst_less_than",    32'(less_than),    32'd1);
    check("midrst_result_valid", 32'(result_valid), 32'd0);
    check("midrst_remainder",    32'(remainder),    32'd0);
    check("midrst_quotient",     32'(quotient),     32'd0);
    check("midrst_div_zero",     32'(div_zero),     32'd0);
    reset_n = 1'b1;

    run_op(8'd100, 8'd3, 8'd1, 8'd33, 1'b0, "a100_b3", -1, mr);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
